// File: rtl/btn_msg_pkg.sv
// btn_msg_pkg: shared definitions for the button message sender.
//   state_t      FSM states of btn_msg_sender
//   ASC_*        ASCII bytes used to build "BTN ddd\r\n"
//   PREFIX_LEN   number of bytes in the "BTN " prefix
//   prefix_char  byte of the prefix at a given index
package btn_msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        DIGITS,
        CR,
        LF
    } state_t;

    localparam logic [7:0] ASC_B  = 8'h42;
    localparam logic [7:0] ASC_T  = 8'h54;
    localparam logic [7:0] ASC_N  = 8'h4E;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    localparam int unsigned PREFIX_LEN = 4;

    function automatic logic [7:0] prefix_char(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = ASC_B;
            2'd1:    c = ASC_T;
            2'd2:    c = ASC_N;
            default: c = ASC_SP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: Digits-wide decimal counter, wraps from all nines to zero.
//   clk_i    system clock
//   rst_i    asynchronous active-high reset, clears the count
//   inc_i    increment request, one count per high cycle
//   count_o  BCD count, digit 0 in [3:0]
module bcd_counter #(
    parameter int unsigned Digits = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    output logic [4*Digits-1:0]   count_o
);

    // carry[i] high means digit i steps this cycle
    logic [Digits:0] carry;

    always_comb begin
        carry    = '0;
        carry[0] = inc_i;
        for (int unsigned i = 0; i < Digits; i++) begin
            carry[i+1] = carry[i] && (count_o[4*i +: 4] == 4'd9);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else begin
            for (int unsigned i = 0; i < Digits; i++) begin
                if (carry[i]) begin
                    if (count_o[4*i +: 4] == 4'd9) begin
                        count_o[4*i +: 4] <= 4'd0;
                    end else begin
                        count_o[4*i +: 4] <= 4'(count_o[4*i +: 4] + 4'd1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/btn_msg_sender.sv
// btn_msg_sender: on each debounced press, bump a BCD press counter and
// write "BTN ddd\r\n" (or "BTN ddd\n") byte by byte into the UART TX FIFO.
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   btn_tick_i   one-cycle press pulse; ignored while a message is in progress
//   fifo_full_i  TX FIFO full, suppresses writes and stalls the message
//   wr_o         FIFO write strobe (one byte per high cycle)
//   wdata_o      byte to write, 8'h00 when idle
//   busy_o       message in progress
//   count_o      BCD press count, digit 0 in [3:0]
module btn_msg_sender
    import btn_msg_pkg::*;
#(
    parameter int unsigned Digits = 3,
    parameter bit          SendCr = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  btn_tick_i,
    input  logic                  fifo_full_i,
    output logic                  wr_o,
    output logic [7:0]            wdata_o,
    output logic                  busy_o,
    output logic [4*Digits-1:0]   count_o
);

    state_t     state;
    logic [1:0] idx;
    logic       accept;
    logic [3:0] digit;

    assign accept = (state == IDLE) && btn_tick_i;

    bcd_counter #(.Digits(Digits)) u_bcd_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (accept),
        .count_o (count_o)
    );

    always_comb begin
        busy_o = (state != IDLE);
        wr_o   = busy_o && !fifo_full_i;
    end

    // count_o already holds the incremented value by the first write cycle
    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < Digits; i++) begin
            if (idx == 2'(i)) begin
                digit = count_o[4*i +: 4];
            end
        end
    end

    always_comb begin
        case (state)
            PREFIX:  wdata_o = prefix_char(idx);
            DIGITS:  wdata_o = ASC_0 + {4'd0, digit};
            CR:      wdata_o = ASC_CR;
            LF:      wdata_o = ASC_LF;
            default: wdata_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_tick_i) begin
                        state <= PREFIX;
                        idx   <= '0;
                    end
                end
                PREFIX: begin
                    if (wr_o) begin
                        if (idx == 2'(PREFIX_LEN - 1)) begin
                            state <= DIGITS;
                            idx   <= 2'(Digits - 1);
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                DIGITS: begin
                    if (wr_o) begin
                        if (idx == 2'd0) begin
                            state <= SendCr ? CR : LF;
                        end else begin
                            idx <= idx - 2'd1;
                        end
                    end
                end
                CR: begin
                    if (wr_o) begin
                        state <= LF;
                    end
                end
                LF: begin
                    if (wr_o) begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_msg_sender.sv
// tb_btn_msg_sender: scoreboard bench for btn_msg_sender.
// Expected message bytes are pushed when a press is driven and popped by a
// negedge monitor on every FIFO write. A second instance covers SendCr=0.
module tb_btn_msg_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_tick = 1'b0;
    logic        fifo_full = 1'b0;
    logic        wr;
    logic [7:0]  wdata;
    logic        busy;
    logic [11:0] count;

    logic        btn_tick2 = 1'b0;
    logic        fifo_full2 = 1'b0;
    logic        wr2;
    logic [7:0]  wdata2;
    logic        busy2;
    logic [11:0] count2;

    int checks = 0;
    int failures = 0;
    int model = 0;

    logic [7:0] q[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    btn_msg_sender #(.Digits(3), .SendCr(1'b1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_tick_i  (btn_tick),
        .fifo_full_i (fifo_full),
        .wr_o        (wr),
        .wdata_o     (wdata),
        .busy_o      (busy),
        .count_o     (count)
    );

    btn_msg_sender #(.Digits(3), .SendCr(1'b0)) dut_lf (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_tick_i  (btn_tick2),
        .fifo_full_i (fifo_full2),
        .wr_o        (wr2),
        .wdata_o     (wdata2),
        .busy_o      (busy2),
        .count_o     (count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] bcd3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic push_msg(input int v, input bit cr, input bit second);
        logic [7:0] m[$];
        m = '{8'h42, 8'h54, 8'h4E, 8'h20,
              8'(8'h30 + v / 100 % 10), 8'(8'h30 + v / 10 % 10), 8'(8'h30 + v % 10)};
        if (cr) m.push_back(8'h0D);
        m.push_back(8'h0A);
        foreach (m[i]) begin
            if (second) q2.push_back(m[i]);
            else        q.push_back(m[i]);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=no_write", wdata);
            end else begin
                chk("byte", {24'd0, wdata}, {24'd0, q.pop_front()});
            end
        end
        if (wr2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write_lf actual=%0h required=no_write", wdata2);
            end else begin
                chk("byte_lf", {24'd0, wdata2}, {24'd0, q2.pop_front()});
            end
        end
    end

    // Press in cycle T; the model count advances and its message is queued.
    task automatic start_press();
        @(posedge clk); #1;
        btn_tick = 1'b1;
        model = (model + 1) % 1000;
        push_msg(model, 1'b1, 1'b0);
    endtask

    // Runs cycles k = 0.. (k=0 is T+1) until busy drops; fifo full for
    // k in [ss, ss+sl), extra tick pulses at k == t1 / t2.
    task automatic follow(input int ss, input int sl, input int t1, input int t2,
                          output int busy_n);
        bit done = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(posedge clk); #1;
            btn_tick  = (k == t1) || (k == t2);
            fifo_full = (k >= ss) && (k < ss + sl);
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            else done = 1'b1;
        end
        fifo_full = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=busy required=idle_within_64");
        end
    endtask

    typedef struct {
        int         ss;
        int         sl;
        int         t1;
        int         exp_busy;
        logic [11:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int b;
        int b2;

        vecs[0] = '{ss: 0, sl: 0, t1: -1, exp_busy: 9,  exp_cnt: 12'h001};
        vecs[1] = '{ss: 5, sl: 3, t1: 1,  exp_busy: 12, exp_cnt: 12'h002};
        vecs[2] = '{ss: 0, sl: 1, t1: -1, exp_busy: 10, exp_cnt: 12'h003};
        vecs[3] = '{ss: 8, sl: 2, t1: -1, exp_busy: 11, exp_cnt: 12'h004};
        vecs[4] = '{ss: 3, sl: 2, t1: 4,  exp_busy: 11, exp_cnt: 12'h005};

        // reset state
        #2;
        chk("rst_wr",    {31'd0, wr},    32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_count", {20'd0, count}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // table: stalls and ignored ticks during a message
        for (int i = 0; i < 5; i++) begin
            start_press();
            follow(vecs[i].ss, vecs[i].sl, vecs[i].t1, -1, b);
            chk($sformatf("busy_cycles_v%0d", i), b, vecs[i].exp_busy);
            chk($sformatf("count_v%0d", i), {20'd0, count}, {20'd0, vecs[i].exp_cnt});
            chk($sformatf("queue_empty_v%0d", i), q.size(), 0);
        end

        // tick in the LF write cycle dropped, tick in the next cycle accepted
        start_press();
        follow(0, 0, 8, 9, b);
        chk("lf_busy", b, 9);
        model = (model + 1) % 1000;
        push_msg(model, 1'b1, 1'b0);
        follow(0, 0, -1, -1, b2);
        chk("after_lf_busy", b2, 9);
        chk("after_lf_count", {20'd0, count}, {20'd0, bcd3(model)});
        chk("after_lf_queue", q.size(), 0);

        // SendCr=0 instance: 8 bytes
        @(posedge clk); #1;
        btn_tick2 = 1'b1;
        push_msg(1, 1'b0, 1'b1);
        b = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            btn_tick2 = 1'b0;
            @(negedge clk);
            if (busy2 === 1'b1) b++;
            else break;
        end
        chk("lf_only_busy", b, 8);
        chk("lf_only_count", {20'd0, count2}, 32'h001);
        chk("lf_only_queue", q2.size(), 0);

        // reset after the 5th byte
        start_press();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            btn_tick = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_wr",    {31'd0, wr},    32'd0);
        chk("midrst_busy",  {31'd0, busy},  32'd0);
        chk("midrst_count", {20'd0, count}, 32'd0);
        q.delete();
        q2.delete();
        model = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        start_press();
        follow(0, 0, -1, -1, b);
        chk("postrst_busy", b, 9);
        chk("postrst_count", {20'd0, count}, 32'h001);
        chk("postrst_queue", q.size(), 0);

        // wrap: 1000 presses from zero end on "BTN 000"
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        model = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            start_press();
            follow(0, 0, -1, -1, b);
            if (n == 998) chk("count_999", {20'd0, count}, 32'h999);
        end
        chk("wrap_busy", b, 9);
        chk("wrap_count", {20'd0, count}, 32'h000);
        chk("wrap_queue", q.size(), 0);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
